ysyx_23060332_sram_slave: RTL and testbench

- Memory responder for the core's data-memory port: the target end of the load/store request interface, replacing the zero-latency combinational mem model.
- Accepts one read or write request at a time over a valid/ready channel and holds a word-addressed 64-bit storage array.
- Returns a response after a programmable latency over a second valid/ready channel.
- Used for multi-cycle LSU bring-up and for stressing core stall logic.

---
 rtl/ysyx_23060332_sram_slave_if.sv | 45 ++++
 rtl/ysyx_23060332_sram_slave.sv | 168 ++++++++++++++++
 tb/tb_ysyx_23060332_sram_slave.sv | 396 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ysyx_23060332_sram_slave_if.sv
// Load/store request and response channels between the core LSU (master) and the
// SRAM responder (slave).
interface ysyx_23060332_sram_slave_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 64
) ();

  logic                  req_valid;
  logic                  req_ready;
  logic                  req_wen;
  logic [ADDR_W-1:0]     req_addr;
  logic [DATA_W-1:0]     req_wdata;
  logic [DATA_W/8-1:0]   req_wmask;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_W-1:0]     rsp_rdata;
  logic                  rsp_err;

  modport slave (
    input  req_valid,
    input  req_wen,
    input  req_addr,
    input  req_wdata,
    input  req_wmask,
    input  rsp_ready,
    output req_ready,
    output rsp_valid,
    output rsp_rdata,
    output rsp_err
  );

  modport master (
    output req_valid,
    output req_wen,
    output req_addr,
    output req_wdata,
    output req_wmask,
    output rsp_ready,
    input  req_ready,
    input  rsp_valid,
    input  rsp_rdata,
    input  rsp_err
  );

endinterface

// File: rtl/ysyx_23060332_sram_slave.sv
// Multi-cycle data-memory responder: one request at a time, response after LATENCY wait cycles.
// Define YSYX_23060332_SRAM_RAND_DELAY_EN to add 0..3 LFSR-driven extra wait cycles per request.
module ysyx_23060332_sram_slave #(
  parameter int unsigned       ADDR_W  = 32,
  parameter int unsigned       DATA_W  = 64,
  parameter int unsigned       DEPTH   = 4096,
  parameter logic [ADDR_W-1:0] BASE    = 32'h8000_0000,
  parameter int unsigned       LATENCY = 1
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  ysyx_23060332_sram_slave_if.slave slv
`ifdef YSYX_23060332_SRAM_RAND_DELAY_EN
  ,
  output logic                      o_rand_dly_active
`endif
);

  localparam int unsigned BYTES = DATA_W / 8;
  localparam int unsigned OFF_W = $clog2(BYTES);
  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(LATENCY + 4) + 1;
  localparam logic [ADDR_W:0] SPAN = (ADDR_W + 1)'(DEPTH * BYTES);

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StResp
  } state_e;

  state_e              r_state;
  logic                r_req_ready;
  logic                r_rsp_valid;
  logic                r_rsp_err;
  logic [DATA_W-1:0]   r_rsp_rdata;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_wen;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic [BYTES-1:0]    r_wmask;
  logic [DATA_W-1:0]   r_mem [DEPTH];

  logic                w_accept;
  logic [CNT_W-1:0]    w_extra;
  logic [CNT_W-1:0]    w_wait_len;
  logic                w_use_req;
  logic                w_acc_wen;
  logic [ADDR_W-1:0]   w_acc_addr;
  logic [DATA_W-1:0]   w_acc_wdata;
  logic [BYTES-1:0]    w_acc_wmask;
  logic                w_access;
  logic [ADDR_W-1:0]   w_off;
  logic                w_in_range;
  logic [IDX_W-1:0]    w_idx;
  logic                w_do_wr;
  logic [DATA_W-1:0]   w_rdata;

  assign w_accept   = (r_state == StIdle) && r_req_ready && slv.req_valid;
  assign w_wait_len = CNT_W'(LATENCY) + w_extra;

  // A zero-length wait accesses on the accept edge, so the live request must feed the array.
  assign w_use_req   = (r_state == StIdle);
  assign w_acc_wen   = w_use_req ? slv.req_wen   : r_wen;
  assign w_acc_addr  = w_use_req ? slv.req_addr  : r_addr;
  assign w_acc_wdata = w_use_req ? slv.req_wdata : r_wdata;
  assign w_acc_wmask = w_use_req ? slv.req_wmask : r_wmask;

  assign w_access = (w_accept && (w_wait_len == '0)) ||
                    ((r_state == StWait) && (r_cnt == CNT_W'(1)));

  assign w_off      = w_acc_addr - BASE;
  assign w_in_range = {1'b0, w_off} < SPAN;
  assign w_idx      = w_off[OFF_W +: IDX_W];
  assign w_do_wr    = w_access && w_acc_wen && w_in_range;
  assign w_rdata    = (w_in_range && !w_acc_wen) ? r_mem[w_idx] : '0;

`ifdef YSYX_23060332_SRAM_RAND_DELAY_EN
  logic [7:0] r_lfsr;
  logic       r_rand_active;

  // x^8 + x^6 + x^5 + x^4 + 1
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_lfsr        <= 8'hA5;
      r_rand_active <= 1'b0;
    end else begin
      r_lfsr <= {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
      if (w_accept) begin
        r_rand_active <= |r_lfsr[1:0];
      end else if ((r_state == StResp) && slv.rsp_ready) begin
        r_rand_active <= 1'b0;
      end
    end
  end

  assign w_extra           = {{(CNT_W - 2){1'b0}}, r_lfsr[1:0]};
  assign o_rand_dly_active = r_rand_active;
`else
  assign w_extra = '0;
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= StIdle;
      r_req_ready <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
      r_cnt       <= '0;
      r_wen       <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_wmask     <= '0;
    end else begin
      unique case (r_state)
        StIdle: begin
          r_req_ready <= !w_accept;
          if (w_accept) begin
            r_wen   <= slv.req_wen;
            r_addr  <= slv.req_addr;
            r_wdata <= slv.req_wdata;
            r_wmask <= slv.req_wmask;
            r_cnt   <= w_wait_len;
            r_state <= w_access ? StResp : StWait;
          end
        end
        StWait: begin
          r_cnt <= r_cnt - CNT_W'(1);
          if (w_access) begin
            r_state <= StResp;
          end
        end
        StResp: begin
          if (slv.rsp_ready) begin
            r_state     <= StIdle;
            r_req_ready <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
          end
        end
        default: r_state <= StIdle;
      endcase
      // Access edge: capture the response; it stays frozen until the rsp handshake.
      if (w_access) begin
        r_rsp_valid <= 1'b1;
        r_rsp_rdata <= w_rdata;
        r_rsp_err   <= !w_in_range;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_do_wr) begin
      for (int i = 0; i < int'(BYTES); i++) begin
        if (w_acc_wmask[i]) begin
          r_mem[w_idx][i*8 +: 8] <= w_acc_wdata[i*8 +: 8];
        end
      end
    end
  end

  assign slv.req_ready = r_req_ready;
  assign slv.rsp_valid = r_rsp_valid;
  assign slv.rsp_rdata = r_rsp_rdata;
  assign slv.rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_ysyx_23060332_sram_slave.sv
// Directed bench for ysyx_23060332_sram_slave: three instances with LATENCY 0, 1 and 3
// share clock and reset; each scenario task checks its own expectations inline.
module tb_ysyx_23060332_sram_slave;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b1;
  int unsigned cyc   = 0;
  int          n_vec = 0;
  int          n_err = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic        req_ready;
    logic        rsp_valid;
    logic [63:0] rdata;
    logic        err;
  } obs_t;

  ysyx_23060332_sram_slave_if #(.ADDR_W(32), .DATA_W(64)) bus_l0 ();
  ysyx_23060332_sram_slave_if #(.ADDR_W(32), .DATA_W(64)) bus_l1 ();
  ysyx_23060332_sram_slave_if #(.ADDR_W(32), .DATA_W(64)) bus_l3 ();

`ifdef YSYX_23060332_SRAM_RAND_DELAY_EN
  logic rd_act0, rd_act1, rd_act3;
`endif

  ysyx_23060332_sram_slave #(.LATENCY(0)) u_dut_l0 (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .slv     (bus_l0)
`ifdef YSYX_23060332_SRAM_RAND_DELAY_EN
    , .o_rand_dly_active (rd_act0)
`endif
  );

  ysyx_23060332_sram_slave #(.LATENCY(1)) u_dut_l1 (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .slv     (bus_l1)
`ifdef YSYX_23060332_SRAM_RAND_DELAY_EN
    , .o_rand_dly_active (rd_act1)
`endif
  );

  ysyx_23060332_sram_slave #(.LATENCY(3)) u_dut_l3 (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .slv     (bus_l3)
`ifdef YSYX_23060332_SRAM_RAND_DELAY_EN
    , .o_rand_dly_active (rd_act3)
`endif
  );

  // sel selects the instance by its latency: 0, 1 or 3.
  function automatic obs_t sample(input int sel);
    obs_t o;
    case (sel)
      0: begin
        o.req_ready = bus_l0.req_ready; o.rsp_valid = bus_l0.rsp_valid;
        o.rdata     = bus_l0.rsp_rdata; o.err       = bus_l0.rsp_err;
      end
      1: begin
        o.req_ready = bus_l1.req_ready; o.rsp_valid = bus_l1.rsp_valid;
        o.rdata     = bus_l1.rsp_rdata; o.err       = bus_l1.rsp_err;
      end
      default: begin
        o.req_ready = bus_l3.req_ready; o.rsp_valid = bus_l3.rsp_valid;
        o.rdata     = bus_l3.rsp_rdata; o.err       = bus_l3.rsp_err;
      end
    endcase
    return o;
  endfunction

  task automatic drive_req(input int sel, input logic v, input logic wen, input logic [31:0] addr,
                           input logic [63:0] wd, input logic [7:0] wm);
    case (sel)
      0: begin
        bus_l0.req_valid = v; bus_l0.req_wen = wen; bus_l0.req_addr = addr;
        bus_l0.req_wdata = wd; bus_l0.req_wmask = wm;
      end
      1: begin
        bus_l1.req_valid = v; bus_l1.req_wen = wen; bus_l1.req_addr = addr;
        bus_l1.req_wdata = wd; bus_l1.req_wmask = wm;
      end
      default: begin
        bus_l3.req_valid = v; bus_l3.req_wen = wen; bus_l3.req_addr = addr;
        bus_l3.req_wdata = wd; bus_l3.req_wmask = wm;
      end
    endcase
  endtask

  task automatic set_rsp_ready(input int sel, input logic r);
    case (sel)
      0:       bus_l0.rsp_ready = r;
      1:       bus_l1.rsp_ready = r;
      default: bus_l3.rsp_ready = r;
    endcase
  endtask

  // Full request/response with rsp_ready held high. lat = edges from the accept edge to the
  // edge after which rsp_valid is seen; acc_cyc = cycle stamp of the accept edge.
  task automatic txn(input int sel, input logic wen, input logic [31:0] addr,
                     input logic [63:0] wd, input logic [7:0] wm,
                     output int lat, output logic [63:0] rdata, output logic err,
                     output int unsigned acc_cyc, output bit post_ok);
    obs_t o;
    int   n;
    set_rsp_ready(sel, 1'b1);
    n = 0;
    o = sample(sel);
    while (!o.req_ready && n < 32) begin
      @(posedge clk); #1; n++; o = sample(sel);
    end
    drive_req(sel, 1'b1, wen, addr, wd, wm);
    @(posedge clk); #1;
    acc_cyc = cyc;
    drive_req(sel, 1'b0, 1'b0, 32'h0, 64'h0, 8'h0);
    lat = 0;
    o = sample(sel);
    while (!o.rsp_valid && lat < 32) begin
      @(posedge clk); #1; lat++; o = sample(sel);
    end
    rdata = o.rdata;
    err   = o.err;
    @(posedge clk); #1;
    o = sample(sel);
    post_ok = (n < 32) && !o.rsp_valid && o.req_ready;
  endtask

  task automatic test_reset();
    obs_t o;
    int   sels [3] = '{0, 1, 3};
    for (int s = 0; s < 3; s++) begin
      drive_req(sels[s], 1'b0, 1'b0, 32'h0, 64'h0, 8'h0);
      set_rsp_ready(sels[s], 1'b0);
    end
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    o = sample(1);
    n_vec++;
    if (o !== obs_t'({1'b0, 1'b0, 64'h0, 1'b0})) begin
      n_err++;
      $display("FAIL reset_outputs: got rdy=%b vld=%b rdata=%h err=%b, want all zero",
               o.req_ready, o.rsp_valid, o.rdata, o.err);
    end
    @(negedge clk) rst_n = 1'b1;
    #1;
    o = sample(1);
    n_vec++;
    if (o.req_ready !== 1'b0) begin
      n_err++; $display("FAIL ready_before_edge: got %b want 0", o.req_ready);
    end
    @(posedge clk); #1;
    for (int s = 0; s < 3; s++) begin
      o = sample(sels[s]);
      n_vec++;
      if (o.req_ready !== 1'b1) begin
        n_err++; $display("FAIL ready_after_release L%0d: got %b want 1", sels[s], o.req_ready);
      end
    end
  endtask

  task automatic test_write_read();
    int lat; logic [63:0] rd; logic err; int unsigned ac; bit ok;
    txn(1, 1'b1, 32'h8000_0010, 64'h1122_3344_5566_7788, 8'hFF, lat, rd, err, ac, ok);
    n_vec++;
    if ({lat, rd, err, ok} !== {32'd1, 64'h0, 1'b0, 1'b1}) begin
      n_err++;
      $display("FAIL wr_full: got lat=%0d rdata=%h err=%b ok=%b want lat=1 rdata=0 err=0 ok=1",
               lat, rd, err, ok);
    end
    txn(1, 1'b0, 32'h8000_0010, 64'h0, 8'h0, lat, rd, err, ac, ok);
    n_vec++;
    if ({lat, rd, err, ok} !== {32'd1, 64'h1122_3344_5566_7788, 1'b0, 1'b1}) begin
      n_err++;
      $display("FAIL rd_full: got lat=%0d rdata=%h err=%b ok=%b want lat=1 rdata=1122334455667788",
               lat, rd, err, ok);
    end
  endtask

  task automatic test_byte_mask();
    int lat; logic [63:0] rd; logic err; int unsigned ac; bit ok;
    txn(1, 1'b1, 32'h8000_0010, 64'hAAAA_AAAA_AAAA_AAAA, 8'h0F, lat, rd, err, ac, ok);
    txn(1, 1'b0, 32'h8000_0010, 64'h0, 8'h0, lat, rd, err, ac, ok);
    n_vec++;
    if (rd !== 64'h1122_3344_AAAA_AAAA) begin
      n_err++; $display("FAIL mask_0f: got %h want 11223344aaaaaaaa", rd);
    end
    // Zero mask is a no-op; low address bits are ignored on the read-back.
    txn(1, 1'b1, 32'h8000_0010, 64'h5555_5555_5555_5555, 8'h00, lat, rd, err, ac, ok);
    txn(1, 1'b0, 32'h8000_0013, 64'h0, 8'h0, lat, rd, err, ac, ok);
    n_vec++;
    if ({rd, err} !== {64'h1122_3344_AAAA_AAAA, 1'b0}) begin
      n_err++; $display("FAIL mask_zero_unaligned: got %h err=%b want 11223344aaaaaaaa err=0",
                        rd, err);
    end
  endtask

  task automatic test_out_of_range();
    int lat; logic [63:0] rd; logic err; int unsigned ac; bit ok;
    txn(1, 1'b1, 32'h8000_0000, 64'hDEAD_BEEF_CAFE_F00D, 8'hFF, lat, rd, err, ac, ok);
    txn(1, 1'b0, 32'h7FFF_FFF8, 64'h0, 8'h0, lat, rd, err, ac, ok);
    n_vec++;
    if ({lat, rd, err} !== {32'd1, 64'h0, 1'b1}) begin
      n_err++; $display("FAIL oor_read: got lat=%0d rdata=%h err=%b want lat=1 rdata=0 err=1",
                        lat, rd, err);
    end
    txn(1, 1'b1, 32'h8000_8000, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, lat, rd, err, ac, ok);
    n_vec++;
    if ({lat, rd, err} !== {32'd1, 64'h0, 1'b1}) begin
      n_err++; $display("FAIL oor_write: got lat=%0d rdata=%h err=%b want lat=1 rdata=0 err=1",
                        lat, rd, err);
    end
    txn(1, 1'b0, 32'h8000_0000, 64'h0, 8'h0, lat, rd, err, ac, ok);
    n_vec++;
    if ({rd, err} !== {64'hDEAD_BEEF_CAFE_F00D, 1'b0}) begin
      n_err++; $display("FAIL oor_no_alias: got %h err=%b want deadbeefcafef00d err=0", rd, err);
    end
    txn(1, 1'b1, 32'h8000_7FF8, 64'h0102_0304_0506_0708, 8'hFF, lat, rd, err, ac, ok);
    txn(1, 1'b0, 32'h8000_7FF8, 64'h0, 8'h0, lat, rd, err, ac, ok);
    n_vec++;
    if ({rd, err} !== {64'h0102_0304_0506_0708, 1'b0}) begin
      n_err++; $display("FAIL last_word: got %h err=%b want 0102030405060708 err=0", rd, err);
    end
  endtask

  task automatic test_backpressure();
    obs_t        o;
    int          n;
    logic [63:0] held;
    set_rsp_ready(1, 1'b0);
    drive_req(1, 1'b1, 1'b0, 32'h8000_0010, 64'h0, 8'h0);
    @(posedge clk); #1;
    drive_req(1, 1'b0, 1'b0, 32'h0, 64'h0, 8'h0);
    n = 0; o = sample(1);
    while (!o.rsp_valid && n < 32) begin
      @(posedge clk); #1; n++; o = sample(1);
    end
    held = o.rdata;
    n_vec++;
    if ({n, held} !== {32'd1, 64'h1122_3344_AAAA_AAAA}) begin
      n_err++; $display("FAIL bp_first: got lat=%0d rdata=%h want lat=1 rdata=11223344aaaaaaaa",
                        n, held);
    end
    // Offer a new request while the response is stalled; it must wait.
    drive_req(1, 1'b1, 1'b0, 32'h8000_0000, 64'h0, 8'h0);
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      o = sample(1);
      n_vec++;
      if ({o.rsp_valid, o.req_ready, o.rdata} !== {1'b1, 1'b0, 64'h1122_3344_AAAA_AAAA}) begin
        n_err++; $display("FAIL bp_hold c%0d: got vld=%b rdy=%b rdata=%h want 1 0 11223344aaaaaaaa",
                          c, o.rsp_valid, o.req_ready, o.rdata);
      end
    end
    set_rsp_ready(1, 1'b1);
    @(posedge clk); #1;
    o = sample(1);
    n_vec++;
    if ({o.rsp_valid, o.req_ready} !== 2'b01) begin
      n_err++; $display("FAIL bp_release: got vld=%b rdy=%b want 0 1", o.rsp_valid, o.req_ready);
    end
    @(posedge clk); #1;
    o = sample(1);
    n_vec++;
    if (o.req_ready !== 1'b0) begin
      n_err++; $display("FAIL bp_reaccept: got rdy=%b want 0", o.req_ready);
    end
    drive_req(1, 1'b0, 1'b0, 32'h0, 64'h0, 8'h0);
    n = 0; o = sample(1);
    while (!o.rsp_valid && n < 32) begin
      @(posedge clk); #1; n++; o = sample(1);
    end
    n_vec++;
    if ({n, o.rdata} !== {32'd1, 64'hDEAD_BEEF_CAFE_F00D}) begin
      n_err++; $display("FAIL bp_second: got lat=%0d rdata=%h want lat=1 rdata=deadbeefcafef00d",
                        n, o.rdata);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_latency();
    int lat; logic [63:0] rd; logic err; int unsigned ac; bit ok;
    txn(0, 1'b1, 32'h8000_0100, 64'h0F0E_0D0C_0B0A_0908, 8'hFF, lat, rd, err, ac, ok);
    n_vec++;
    if ({lat, ok} !== {32'd0, 1'b1}) begin
      n_err++; $display("FAIL l0_write: got lat=%0d ok=%b want lat=0 ok=1", lat, ok);
    end
    txn(0, 1'b0, 32'h8000_0100, 64'h0, 8'h0, lat, rd, err, ac, ok);
    n_vec++;
    if ({lat, rd} !== {32'd0, 64'h0F0E_0D0C_0B0A_0908}) begin
      n_err++; $display("FAIL l0_read: got lat=%0d rdata=%h want lat=0 rdata=0f0e0d0c0b0a0908",
                        lat, rd);
    end
    txn(3, 1'b1, 32'h8000_0100, 64'h7766_5544_3322_1100, 8'hFF, lat, rd, err, ac, ok);
    n_vec++;
    if ({lat, ok} !== {32'd3, 1'b1}) begin
      n_err++; $display("FAIL l3_write: got lat=%0d ok=%b want lat=3 ok=1", lat, ok);
    end
    txn(3, 1'b0, 32'h8000_0100, 64'h0, 8'h0, lat, rd, err, ac, ok);
    n_vec++;
    if ({lat, rd} !== {32'd3, 64'h7766_5544_3322_1100}) begin
      n_err++; $display("FAIL l3_read: got lat=%0d rdata=%h want lat=3 rdata=7766554433221100",
                        lat, rd);
    end
  endtask

  task automatic test_back_to_back();
    int          sels  [3] = '{0, 1, 3};
    logic [31:0] addrs [3] = '{32'h8000_0100, 32'h8000_0010, 32'h8000_0100};
    logic [63:0] datas [3] = '{64'h0F0E_0D0C_0B0A_0908, 64'h1122_3344_AAAA_AAAA,
                               64'h7766_5544_3322_1100};
    int lat; logic [63:0] rd1, rd2; logic err; int unsigned ac1, ac2; bit ok;
    for (int s = 0; s < 3; s++) begin
      txn(sels[s], 1'b0, addrs[s], 64'h0, 8'h0, lat, rd1, err, ac1, ok);
      txn(sels[s], 1'b0, addrs[s], 64'h0, 8'h0, lat, rd2, err, ac2, ok);
      n_vec++;
      if ({ac2 - ac1, rd1, rd2} !== {32'(sels[s] + 2), datas[s], datas[s]}) begin
        n_err++; $display("FAIL b2b L%0d: got spacing=%0d rdata=%h/%h want spacing=%0d rdata=%h",
                          sels[s], ac2 - ac1, rd1, rd2, sels[s] + 2, datas[s]);
      end
    end
  endtask

  task automatic test_reset_mid_wait();
    obs_t o;
    int   seen;
    int lat; logic [63:0] rd; logic err; int unsigned ac; bit ok;
    txn(3, 1'b1, 32'h8000_0020, 64'h0123_4567_89AB_CDEF, 8'hFF, lat, rd, err, ac, ok);
    set_rsp_ready(3, 1'b1);
    drive_req(3, 1'b1, 1'b1, 32'h8000_0020, 64'hFFFF_0000_FFFF_0000, 8'hFF);
    @(posedge clk); #1;
    drive_req(3, 1'b0, 1'b0, 32'h0, 64'h0, 8'h0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    o = sample(3);
    n_vec++;
    if (o !== obs_t'({1'b0, 1'b0, 64'h0, 1'b0})) begin
      n_err++; $display("FAIL mid_reset_clear: got rdy=%b vld=%b rdata=%h err=%b want all zero",
                        o.req_ready, o.rsp_valid, o.rdata, o.err);
    end
    seen = 0;
    repeat (4) begin
      @(posedge clk); #1;
      if (bus_l3.rsp_valid !== 1'b0) seen++;
    end
    @(negedge clk) rst_n = 1'b1;
    repeat (6) begin
      @(posedge clk); #1;
      if (bus_l3.rsp_valid !== 1'b0) seen++;
    end
    n_vec++;
    if (seen !== 0) begin
      n_err++; $display("FAIL mid_reset_no_rsp: got %0d valid cycles want 0", seen);
    end
    txn(3, 1'b0, 32'h8000_0020, 64'h0, 8'h0, lat, rd, err, ac, ok);
    n_vec++;
    if ({rd, lat} !== {64'h0123_4567_89AB_CDEF, 32'd3}) begin
      n_err++; $display("FAIL mid_reset_old: got %h lat=%0d want 0123456789abcdef lat=3", rd, lat);
    end
    // Reset while a read response is stalled must clear the held data at once.
    set_rsp_ready(1, 1'b0);
    drive_req(1, 1'b1, 1'b0, 32'h8000_0000, 64'h0, 8'h0);
    @(posedge clk); #1;
    drive_req(1, 1'b0, 1'b0, 32'h0, 64'h0, 8'h0);
    @(posedge clk); #1;
    o = sample(1);
    rst_n = 1'b0;
    #1;
    o = sample(1);
    n_vec++;
    if ({o.rsp_valid, o.rdata} !== {1'b0, 64'h0}) begin
      n_err++; $display("FAIL resp_reset_clear: got vld=%b rdata=%h want 0 0", o.rsp_valid, o.rdata);
    end
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_byte_mask();
    test_out_of_range();
    test_backpressure();
    test_latency();
    test_back_to_back();
    test_reset_mid_wait();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
